// File: rtl/tex_bilerp.sv
// Bilinear texture filter: two-stage valid/ready pipeline blending four A8R8G8B8 texels
// with u/v fractional weights; point requests pass t00 through with identical latency.
module tex_bilerp #(
  parameter int CORE_ID   = 0,
  parameter int FRAC_BITS = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_filter,
  input  logic [127:0]         req_texels,
  input  logic [FRAC_BITS-1:0] req_alpha,
  input  logic [FRAC_BITS-1:0] req_beta,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic [31:0]          rsp_texel
);

  localparam int PW = 8 + FRAC_BITS + 1;

  function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [FRAC_BITS-1:0] w);
    logic [PW-1:0] wa;
    logic [PW-1:0] wb;
    logic [PW-1:0] sum;
    wb  = PW'(w);
    wa  = (PW'(1) << FRAC_BITS) - wb;
    sum = PW'(a) * wa + PW'(b) * wb + (PW'(1) << (FRAC_BITS - 1));
    lerp8 = 8'(sum >> FRAC_BITS);
  endfunction

  function automatic logic [31:0] lerp32(input logic [31:0] a, input logic [31:0] b,
                                         input logic [FRAC_BITS-1:0] w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = lerp8(a[8*i +: 8], b[8*i +: 8], w);
    end
    lerp32 = r;
  endfunction

  logic                 en_s;
  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_s0_q, s1_s0_d;
  logic [31:0]          s1_s1_q, s1_s1_d;
  logic [31:0]          s1_t00_q, s1_t00_d;
  logic [FRAC_BITS-1:0] s1_beta_q, s1_beta_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s1_filter_q, s1_filter_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]          rsp_texel_q, rsp_texel_d;

  // A single enable freezes the whole pipe while the response is stalled.
  assign en_s      = !rsp_valid_q || rsp_ready;
  assign req_ready = en_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_texel = rsp_texel_q;

  // Next-state for both stages: horizontal blend in stage 1, vertical blend or t00 in stage 2.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_s0_d     = s1_s0_q;
    s1_s1_d     = s1_s1_q;
    s1_t00_d    = s1_t00_q;
    s1_beta_d   = s1_beta_q;
    s1_tag_d    = s1_tag_q;
    s1_filter_d = s1_filter_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_texel_d = rsp_texel_q;
    if (en_s) begin
      s1_valid_d  = req_valid;
      s1_s0_d     = lerp32(req_texels[31:0], req_texels[63:32], req_alpha);
      s1_s1_d     = lerp32(req_texels[95:64], req_texels[127:96], req_alpha);
      s1_t00_d    = req_texels[31:0];
      s1_beta_d   = req_beta;
      s1_tag_d    = req_tag;
      s1_filter_d = req_filter;
      rsp_valid_d = s1_valid_q;
      rsp_tag_d   = s1_tag_q;
      if (s1_filter_q) begin
        rsp_texel_d = lerp32(s1_s0_q, s1_s1_q, s1_beta_q);
      end else begin
        rsp_texel_d = s1_t00_q;
      end
    end else begin
      s1_valid_d  = s1_valid_q;
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Valids and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_texel_q <= 32'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_texel_q <= rsp_texel_d;
    end
  end

  // Stage-1 payload; contents are ignored while its valid is low, so no reset.
  always_ff @(posedge clk) begin
    s1_s0_q     <= s1_s0_d;
    s1_s1_q     <= s1_s1_d;
    s1_t00_q    <= s1_t00_d;
    s1_beta_q   <= s1_beta_d;
    s1_tag_q    <= s1_tag_d;
    s1_filter_q <= s1_filter_d;
  end

endmodule
